// File: rtl/alu_seq_exec.sv
// Execution ALU with single-cycle arithmetic/logic and iterative one-bit-per-clock shifts.
// Define ALU_BARREL_SHIFT_EN to compute shifts combinationally with single-cycle latency.
module alu_seq_exec #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [3:0]         ALU_Operation_i,
    input  logic [XLEN-1:0]    A_i,
    input  logic [XLEN-1:0]    B_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [XLEN-1:0]    result_o,
    output logic               zero_o
);

    typedef enum logic {IDLE, SHIFT} state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_XOR   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_AND   = 4'b0100,
        OP_SLL   = 4'b0101,
        OP_SRL   = 4'b0110,
        OP_SRA   = 4'b0111,
        OP_SLT   = 4'b1000,
        OP_PASSB = 4'b1001
    } alu_op_e;

    state_e              state_q, state_n;
    alu_op_e             kind_q, kind_n;
    logic [XLEN-1:0]     sh_q, sh_n;
    logic [SHAMT_W-1:0]  cnt_q, cnt_n;
    logic [XLEN-1:0]     result_n;
    logic                zero_n;
    logic                done_n;
    logic [SHAMT_W-1:0]  shamt;

    assign shamt = B_i[SHAMT_W-1:0];

    // SRA repeats the current MSB, which stays equal to the sign of latched A.
    function automatic logic [XLEN-1:0] shift_one(input logic [XLEN-1:0] v, input alu_op_e k);
        case (k)
            OP_SLL:  shift_one = {v[XLEN-2:0], 1'b0};
            OP_SRL:  shift_one = {1'b0, v[XLEN-1:1]};
            default: shift_one = {v[XLEN-1], v[XLEN-1:1]};
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            kind_q   <= OP_SLL;
            sh_q     <= '0;
            cnt_q    <= '0;
            result_o <= '0;
            zero_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state_q  <= state_n;
            kind_q   <= kind_n;
            sh_q     <= sh_n;
            cnt_q    <= cnt_n;
            result_o <= result_n;
            zero_o   <= zero_n;
            done_o   <= done_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        kind_n   = kind_q;
        sh_n     = sh_q;
        cnt_n    = cnt_q;
        result_n = result_o;
        done_n   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    done_n = 1'b1;
                    case (ALU_Operation_i)
                        OP_ADD:   result_n = A_i + B_i;
                        OP_SUB:   result_n = A_i - B_i;
                        OP_XOR:   result_n = A_i ^ B_i;
                        OP_OR:    result_n = A_i | B_i;
                        OP_AND:   result_n = A_i & B_i;
                        OP_SLT:   result_n = {{(XLEN-1){1'b0}}, ($signed(A_i) < $signed(B_i))};
                        OP_PASSB: result_n = B_i;
                        OP_SLL, OP_SRL, OP_SRA: begin
`ifdef ALU_BARREL_SHIFT_EN
                            case (ALU_Operation_i)
                                OP_SLL:  result_n = A_i << shamt;
                                OP_SRL:  result_n = A_i >> shamt;
                                default: result_n = XLEN'($signed(A_i) >>> shamt);
                            endcase
`else
                            if (shamt == '0) begin
                                result_n = A_i;
                            end else if (shamt == SHAMT_W'(1)) begin
                                result_n = shift_one(A_i, alu_op_e'(ALU_Operation_i));
                            end else begin
                                done_n  = 1'b0;
                                kind_n  = alu_op_e'(ALU_Operation_i);
                                sh_n    = shift_one(A_i, alu_op_e'(ALU_Operation_i));
                                cnt_n   = shamt - SHAMT_W'(1);
                                state_n = SHIFT;
                            end
`endif
                        end
                        default:  result_n = '0;
                    endcase
                end
            end
            SHIFT: begin
                sh_n  = shift_one(sh_q, kind_q);
                cnt_n = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_n = sh_n;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        zero_n = done_n ? (result_n == '0) : zero_o;
    end

`ifdef ALU_BARREL_SHIFT_EN
    assign busy_o = 1'b0;
`else
    assign busy_o = (state_q == SHIFT);
`endif

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed self-checking bench for alu_seq_exec (default iterative-shift build).
module tb_alu_seq_exec;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [3:0]  ALU_Operation_i;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;

    int errors = 0;
    int checks = 0;

    alu_seq_exec #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .ALU_Operation_i (ALU_Operation_i),
        .A_i             (A_i),
        .B_i             (B_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .result_o        (result_o),
        .zero_o          (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse at the current negedge; returns at the negedge after edge 0.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        ALU_Operation_i = op;
        A_i     = a;
        B_i     = b;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        A_i     = 32'h5A5A_C3C3;
        B_i     = 32'h0000_0013;
        ALU_Operation_i = 4'b0001;
    endtask

    // Wait (bounded) for done_o, then check latency, result and zero flag.
    task automatic finish_op(input string tag, input int exp_lat,
                             input logic [31:0] exp_res, input logic exp_zero);
        int lat = 1;
        while (done_o !== 1'b1 && lat <= 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result_o, exp_res);
        check({tag, "_zero"}, {31'b0, zero_o}, {31'b0, exp_zero});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        start_i = 1'b0;
        ALU_Operation_i = 4'b0000;
        A_i = '0;
        B_i = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_res", result_o, 32'd0);
        check("rst_zero", {31'b0, zero_o}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        issue(4'b0000, 32'd5, 32'd7);
        finish_op("add", 1, 32'h0000_000C, 1'b0);
        @(negedge clk);
        check("add_done_once", {31'b0, done_o}, 32'd0);

        issue(4'b0001, 32'd3, 32'd5);
        finish_op("sub", 1, 32'hFFFF_FFFE, 1'b0);
        @(negedge clk);

        // Reset asserted in the middle of an SLL by 20
        issue(4'b0101, 32'd1, 32'd20);
        repeat (4) @(negedge clk);
        check("midrst_busy_before", {31'b0, busy_o}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        check("midrst_done", {31'b0, done_o}, 32'd0);
        check("midrst_res", result_o, 32'd0);
        check("midrst_zero", {31'b0, zero_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("postrst_busy", {31'b0, busy_o}, 32'd0);
        issue(4'b0000, 32'd1, 32'd1);
        finish_op("postrst_add", 1, 32'd2, 1'b0);
        @(negedge clk);

        // SRA by 4 with an ignored start pulse while busy
        issue(4'b0111, 32'h8000_0000, 32'd4);
        check("sra_busy_c1", {31'b0, busy_o}, 32'd1);
        ALU_Operation_i = 4'b0000;
        A_i = 32'd1;
        B_i = 32'd1;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("sra_busy_c2", {31'b0, busy_o}, 32'd1);
        @(negedge clk);
        check("sra_busy_c3", {31'b0, busy_o}, 32'd1);
        check("sra_done_c3", {31'b0, done_o}, 32'd0);
        @(negedge clk);
        check("sra_done_c4", {31'b0, done_o}, 32'd1);
        check("sra_busy_c4", {31'b0, busy_o}, 32'd0);
        check("sra_res", result_o, 32'hF800_0000);
        @(negedge clk);
        check("sra_done_c5", {31'b0, done_o}, 32'd0);
        check("sra_res_held", result_o, 32'hF800_0000);

        issue(4'b0110, 32'hFFFF_FFFF, 32'd31);
        finish_op("srl31", 31, 32'h0000_0001, 1'b0);
        @(negedge clk);

        issue(4'b0101, 32'hA5A5_0001, 32'd0);
        finish_op("sll0", 1, 32'hA5A5_0001, 1'b0);
        @(negedge clk);

        issue(4'b0101, 32'h0000_0003, 32'h0000_0025);
        finish_op("sll_b25", 5, 32'h0000_0060, 1'b0);
        @(negedge clk);

        issue(4'b0011, 32'h0000_00F0, 32'h0000_000F);
        finish_op("or", 1, 32'h0000_00FF, 1'b0);
        @(negedge clk);
        issue(4'b0100, 32'h0000_F0F0, 32'h0000_FF00);
        finish_op("and", 1, 32'h0000_F000, 1'b0);
        @(negedge clk);
        issue(4'b1001, 32'h1111_1111, 32'hDEAD_BEEF);
        finish_op("passb", 1, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);

        issue(4'b1000, 32'hFFFF_FFFF, 32'd1);
        finish_op("slt", 1, 32'd1, 1'b0);
        // XOR started in the cycle done_o is high
        issue(4'b0010, 32'h0000_1234, 32'h0000_1234);
        finish_op("xor_b2b", 1, 32'd0, 1'b1);
        @(negedge clk);

        issue(4'b1111, 32'd5, 32'd6);
        finish_op("reserved", 1, 32'd0, 1'b1);
        @(negedge clk);
        check("reserved_done_once", {31'b0, done_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
